osel_bank: RTL and testbench
============================

// Module: osel_bank
// PURPOSE
//   Parametrised select-register bank: NSLOT slots of SLOT_W bits, exposed flat on osel.
//   Single-bit latch generalised: slot index, 4 write modes, valid/ready handshake.
//   Adds a multi-cycle sweep-clear sequencer and a sticky error flag.
//   Sits beside the core decode path and holds selects derived from latched instruction fields.
// PARAMETERS
//   NSLOT   8   number of slots (>=2; need not be a power of two)
//   SLOT_W  1   bits per slot; defaults give an 8-bit osel
//   IDX_W   $clog2(NSLOT) localparam, width of wr_idx
// PORTS
//   clk       in   1             rising-edge clock, single domain
//   reset     in   1             synchronous, active-high reset
//   wr_valid  in   1             write request
//   wr_ready  out  1             write can be accepted this cycle
//   wr_idx    in   IDX_W         target slot
//   wr_mode   in   2             00 WRITE, 01 SET (OR), 10 CLEAR (AND~), 11 TOGGLE (XOR)
//   wr_data   in   SLOT_W        operand for wr_mode
//   clr_req   in   1             start a sweep clear (pulse or level)
//   busy      out  1             sweep in progress
//   err       out  1             sticky: out-of-range index accepted
//   osel      out  NSLOT*SLOT_W  slot k = osel[k*SLOT_W +: SLOT_W]
//   osel_par  out  NSLOT         only with OSEL_PARITY_EN: even parity per slot
// BEHAVIOUR
//   - Reset: osel=0, err=0, busy=0, state IDLE, sweep pointer=0. Overrides everything, mid-sweep too.
//   - wr_ready = (state==IDLE) && !clr_req; combinational, no dependence on wr_valid.
//   - Accept = wr_valid && wr_ready. Slot is updated at the same edge; visible on osel next cycle.
//     Latency is 1 clock. Only slot wr_idx changes; all other slots hold.
//   - Mode ops are bitwise on SLOT_W bits: WRITE s=d; SET s|=d; CLEAR s&=~d; TOGGLE s^=d.
//   - wr_idx >= NSLOT: the write is accepted (handshake completes), no slot changes, err<=1.
//   - err stays at 1 until reset or until the first SWEEP cycle.
//   - FSM IDLE->SWEEP when clr_req=1 in IDLE. clr_req takes priority over a same-cycle wr_valid;
//     that write is not accepted.
//   - SWEEP: each cycle clears slot ptr and increments ptr. After ptr==NSLOT-1 is cleared,
//     ptr<=0 and state<=IDLE. Sweep lasts exactly NSLOT cycles. The first cycle also clears err.
//   - busy=1 for exactly the NSLOT SWEEP cycles. wr_ready=0 throughout.
//     clr_req is ignored during SWEEP; it is not queued.
//   - A clr_req still high on return to IDLE starts a new sweep; the IDLE cycle in between is
//     not counted, so there is one idle cycle between sweeps.
//   - No combinational path from inputs to osel/err/busy. wr_ready is the only comb output.
// CONFIGURATION
//   OSEL_PARITY_EN defined: osel_par[k] = ^slot k, registered.
//     Updates on the same edge as the slot, so it is always coherent with osel.
//   Undefined: osel_par port and parity logic are absent. Other behaviour is identical.
// STRUCTURE
//   Package osel_pkg holds:
//     - wr_mode encodings as localparams: MODE_WRITE, MODE_SET, MODE_CLEAR, MODE_TOGGLE
//     - FSM state typedef: ST_IDLE, ST_SWEEP
//     - function osel_apply(mode, old, data) returning the new slot value
//   One sub-module, osel_slot: holds one slot register plus optional parity bit.
//     Inputs: we, clr, mode, data. Instantiated NSLOT times in a generate loop.
//   Top level keeps the FSM, sweep pointer, err, handshake and index decode.
// TESTING
//   1. Defaults, reset then WRITE idx3 data1 -> osel=8'h08 one cycle after accept; wr_ready=1.
//   2. SLOT_W=4 NSLOT=4: WRITE idx1 4'hA, SET 4'h5, TOGGLE 4'h3, CLEAR 4'h8
//      -> slot1 = A, F, C, 4 on successive cycles; other slots stay 0.
//   3. NSLOT=6: write idx7 -> accepted, osel unchanged, err=1. Then clr_req -> err=0 on sweep
//      start, busy high for 6 cycles, osel=0.
//   4. clr_req and wr_valid in the same cycle -> write not accepted, sweep starts.
//      wr_ready=0 for 6 cycles; a write held valid lands in the first IDLE cycle.
//   5. reset asserted in sweep cycle 3 -> next cycle busy=0, osel=0, wr_ready=1.
//   6. OSEL_PARITY_EN, SLOT_W=4: write 4'b0111 to idx2 -> osel_par[2]=1. TOGGLE 4'b0001
//      -> osel_par[2]=0. Build without the macro -> port absent and tests 1-5 pass.

Source files
------------

// File: rtl/osel_pkg.sv
// -----------------------------------------------------------------------------
// osel_pkg
//   Shared definitions for the osel_bank select-register bank:
//     - wr_mode encodings (MODE_WRITE / MODE_SET / MODE_CLEAR / MODE_TOGGLE)
//     - sweep sequencer state type (ST_IDLE / ST_SWEEP)
//     - osel_apply(): the per-bit update rule for one write mode.
//   The mode operations are purely bitwise, so osel_apply works on a single
//   bit and callers loop it over the slot width. That keeps the package
//   independent of SLOT_W.
// -----------------------------------------------------------------------------
package osel_pkg;

  localparam logic [1:0] MODE_WRITE  = 2'b00;  // s  = d
  localparam logic [1:0] MODE_SET    = 2'b01;  // s |= d
  localparam logic [1:0] MODE_CLEAR  = 2'b10;  // s &= ~d
  localparam logic [1:0] MODE_TOGGLE = 2'b11;  // s ^= d

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } osel_state_e;

  // New value of one slot bit, given the mode, the old bit and the operand bit.
  function automatic logic osel_apply(input logic [1:0] mode,
                                      input logic       old_bit,
                                      input logic       data_bit);
    logic res;
    case (mode)
      MODE_WRITE:  res = data_bit;
      MODE_SET:    res = old_bit | data_bit;
      MODE_CLEAR:  res = old_bit & ~data_bit;
      default:     res = old_bit ^ data_bit;  // MODE_TOGGLE
    endcase
    return res;
  endfunction

endpackage

// File: rtl/osel_slot.sv
// -----------------------------------------------------------------------------
// osel_slot
//   One slot of the select bank: a SLOT_W-bit register updated by a write
//   (we + mode + data) or zeroed by the sweep sequencer (clr).
//   With OSEL_PARITY_EN defined, a registered even-parity bit is kept that is
//   loaded on the same edge as the slot, so it always matches the slot value.
// Ports
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset
//   we    in   apply mode/data to this slot this cycle
//   clr   in   zero this slot this cycle (sweep); never concurrent with we
//   mode  in   write mode (see osel_pkg)
//   data  in   SLOT_W operand
//   slot  out  registered slot value
//   par   out  registered ^slot (only with OSEL_PARITY_EN)
// -----------------------------------------------------------------------------
module osel_slot
  import osel_pkg::*;
#(
  parameter int SLOT_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              clr,
  input  logic [1:0]        mode,
  input  logic [SLOT_W-1:0] data,
  output logic [SLOT_W-1:0] slot
`ifdef OSEL_PARITY_EN
  ,output logic             par
`endif
);

  logic [SLOT_W-1:0] slot_d, slot_q;

  always_comb begin
    // NOTE: assigning the hold value first means every path drives slot_d,
    // so no latch is inferred when neither we nor clr is set.
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (we) begin
      for (int i = 0; i < SLOT_W; i++) begin
        slot_d[i] = osel_apply(mode, slot_q[i], data[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot = slot_q;

`ifdef OSEL_PARITY_EN
  logic par_q;

  // Parity is computed from slot_d so it lands on the same edge as the slot.
  always_ff @(posedge clk) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= ^slot_d;
  end

  assign par = par_q;
`endif

endmodule

// File: rtl/osel_bank.sv
// -----------------------------------------------------------------------------
// osel_bank
//   Select-register bank: NSLOT slots of SLOT_W bits, exposed flat on osel
//   (slot k = osel[k*SLOT_W +: SLOT_W]). Writes use a valid/ready handshake
//   and one of four bitwise modes. A clr_req starts a sweep that zeroes one
//   slot per cycle for NSLOT cycles. err is a sticky flag for an accepted
//   write whose index is out of range.
//   Optional feature macro: OSEL_PARITY_EN adds osel_par (registered even
//   parity per slot).
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (overrides everything)
//   wr_valid  in   write request
//   wr_ready  out  write can be accepted (combinational: IDLE && !clr_req)
//   wr_idx    in   target slot
//   wr_mode   in   00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
//   wr_data   in   operand
//   clr_req   in   start a sweep clear
//   busy      out  sweep in progress (registered)
//   err       out  sticky out-of-range flag (registered)
//   osel      out  flat slot contents (registered)
//   osel_par  out  per-slot even parity (only with OSEL_PARITY_EN)
// -----------------------------------------------------------------------------
module osel_bank
  import osel_pkg::*;
#(
  parameter  int NSLOT  = 8,
  parameter  int SLOT_W = 1,
  localparam int IDX_W  = $clog2(NSLOT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [1:0]              wr_mode,
  input  logic [SLOT_W-1:0]       wr_data,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    err,
  output logic [NSLOT*SLOT_W-1:0] osel
`ifdef OSEL_PARITY_EN
  ,output logic [NSLOT-1:0]       osel_par
`endif
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NSLOT - 1);

  osel_state_e      state_d, state_q;
  logic [IDX_W-1:0] ptr_d, ptr_q;
  logic             err_d, err_q;

  logic accept;
  logic idx_in_range;
  logic sweeping;

  // clr_req in IDLE wins over a same-cycle write, hence it gates wr_ready.
  assign wr_ready     = (state_q == ST_IDLE) && !clr_req;
  assign accept       = wr_valid && wr_ready;
  // NSLOT need not be a power of two, so some encodable indices are invalid.
  assign idx_in_range = (32'(wr_idx) < NSLOT);
  assign sweeping     = (state_q == ST_SWEEP);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
        end else if (accept && !idx_in_range) begin
          err_d = 1'b1;
        end
      end
      default: begin  // ST_SWEEP
        if (ptr_q == '0) err_d = 1'b0;
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign busy = sweeping;
  assign err  = err_q;

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    logic slot_we;
    logic slot_clr;

    // Out-of-range indices never match any k, so no slot changes for them.
    assign slot_we  = accept && (wr_idx == IDX_W'(k));
    assign slot_clr = sweeping && (ptr_q == IDX_W'(k));

    osel_slot #(
      .SLOT_W (SLOT_W)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .we    (slot_we),
      .clr   (slot_clr),
      .mode  (wr_mode),
      .data  (wr_data),
      .slot  (osel[k*SLOT_W +: SLOT_W])
`ifdef OSEL_PARITY_EN
      ,.par  (osel_par[k])
`endif
    );
  end

endmodule

// File: tb/tb_osel_bank.sv
// -----------------------------------------------------------------------------
// tb_osel_bank
//   Self-checking bench for osel_bank (NSLOT=6, SLOT_W=4). A behavioural model
//   (slot array, sweep position, sticky error) is stepped on every clock and
//   compared against all DUT outputs every cycle; directed sequences add
//   hand-computed literal expectations, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_osel_bank;

  localparam int NSLOT  = 6;
  localparam int SLOT_W = 4;
  localparam int IDX_W  = $clog2(NSLOT);
  localparam int OW     = NSLOT * SLOT_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [IDX_W-1:0]  wr_idx = '0;
  logic [1:0]        wr_mode = 2'b00;
  logic [SLOT_W-1:0] wr_data = '0;
  logic              clr_req = 1'b0;
  logic              busy;
  logic              err;
  logic [OW-1:0]     osel;
`ifdef OSEL_PARITY_EN
  logic [NSLOT-1:0]  osel_par;
`endif

  osel_bank #(
    .NSLOT  (NSLOT),
    .SLOT_W (SLOT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_idx   (wr_idx),
    .wr_mode  (wr_mode),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .busy     (busy),
    .err      (err),
    .osel     (osel)
`ifdef OSEL_PARITY_EN
    ,.osel_par (osel_par)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  int m_slot [NSLOT];
  int m_err;
  int m_sweep;  // -1 when idle, else index of the slot cleared this cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [OW-1:0] model_osel();
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < NSLOT; k++) v[k*SLOT_W +: SLOT_W] = SLOT_W'(m_slot[k]);
    return v;
  endfunction

  function automatic int parity_of(input int v);
    int p;
    p = 0;
    for (int b = 0; b < SLOT_W; b++) p ^= (v >> b) & 1;
    return p;
  endfunction

  // Advance the model by one clock edge from the inputs applied this cycle.
  task automatic model_step();
    int d;
    int mask;
    mask = (1 << SLOT_W) - 1;
    d    = int'(wr_data);
    if (reset) begin
      for (int k = 0; k < NSLOT; k++) m_slot[k] = 0;
      m_err   = 0;
      m_sweep = -1;
    end else if (m_sweep >= 0) begin
      m_slot[m_sweep] = 0;
      if (m_sweep == 0) m_err = 0;
      m_sweep++;
      if (m_sweep == NSLOT) m_sweep = -1;
    end else if (clr_req) begin
      m_sweep = 0;
    end else if (wr_valid) begin
      if (int'(wr_idx) >= NSLOT) begin
        m_err = 1;
      end else begin
        case (wr_mode)
          2'b00: m_slot[wr_idx] = d;
          2'b01: m_slot[wr_idx] = m_slot[wr_idx] | d;
          2'b10: m_slot[wr_idx] = m_slot[wr_idx] & ~d & mask;
          default: m_slot[wr_idx] = m_slot[wr_idx] ^ d;
        endcase
      end
    end
  endtask

  // The one per-cycle compare against the model.
  task automatic compare_all();
    check("osel", 64'(osel), 64'(model_osel()));
    check("busy", 64'(busy), 64'(m_sweep >= 0));
    check("err", 64'(err), 64'(m_err));
    check("wr_ready", 64'(wr_ready), 64'((m_sweep < 0) && !clr_req));
`ifdef OSEL_PARITY_EN
    for (int k = 0; k < NSLOT; k++)
      check("osel_par", 64'(osel_par[k]), 64'(parity_of(m_slot[k])));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, compare, then step the
  // model just after the rising edge (inputs are still held then).
  task automatic step(input logic rst, input logic v, input int idx,
                      input logic [1:0] mode, input int data, input logic clr);
    @(negedge clk);
    reset    = rst;
    wr_valid = v;
    wr_idx   = IDX_W'(idx);
    wr_mode  = mode;
    wr_data  = SLOT_W'(data);
    clr_req  = clr;
    #1;
    compare_all();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 0, 2'b00, 0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < NSLOT; k++) m_slot[k] = 0;
    m_err   = 0;
    m_sweep = -1;

    // Reset state.
    step(1'b1, 1'b0, 0, 2'b00, 0, 1'b0);
    step(1'b1, 1'b0, 0, 2'b00, 0, 1'b0);
    check("rst_osel", 64'(osel), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_ready", 64'(wr_ready), 64'h1);

    // WRITE idx3 data1: visible one cycle after accept.
    step(1'b0, 1'b1, 3, 2'b00, 1, 1'b0);
    check("write_idx3", 64'(osel), 64'h001000);

    // Mode sequence on slot 1: A, F, C, 4.
    step(1'b0, 1'b1, 1, 2'b00, 4'hA, 1'b0);
    check("mode_write", 64'(osel), 64'h0010A0);
    step(1'b0, 1'b1, 1, 2'b01, 4'h5, 1'b0);
    check("mode_set", 64'(osel), 64'h0010F0);
    step(1'b0, 1'b1, 1, 2'b11, 4'h3, 1'b0);
    check("mode_toggle", 64'(osel), 64'h0010C0);
    step(1'b0, 1'b1, 1, 2'b10, 4'h8, 1'b0);
    check("mode_clear", 64'(osel), 64'h001040);

    // Out-of-range index: accepted, no slot change, sticky err.
    step(1'b0, 1'b1, 7, 2'b00, 4'hF, 1'b0);
    check("oor_osel", 64'(osel), 64'h001040);
    check("oor_err", 64'(err), 64'h1);
    idle_step();
    check("err_sticky", 64'(err), 64'h1);

    // clr_req with a same-cycle write: write dropped, sweep starts.
    step(1'b0, 1'b1, 2, 2'b00, 4'h5, 1'b1);
    check("clr_nowrite", 64'(osel), 64'h001040);
    check("sweep_busy", 64'(busy), 64'h1);
    // Hold the write valid across the sweep; it lands in the first IDLE cycle.
    step(1'b0, 1'b1, 2, 2'b00, 4'h5, 1'b0);
    check("err_cleared", 64'(err), 64'h0);
    for (int c = 1; c < NSLOT; c++) step(1'b0, 1'b1, 2, 2'b00, 4'h5, 1'b0);
    check("sweep_done_busy", 64'(busy), 64'h0);
    check("sweep_done_osel", 64'(osel), 64'h0);
    step(1'b0, 1'b1, 2, 2'b00, 4'h5, 1'b0);
    check("held_write", 64'(osel), 64'h000500);

    // Reset during sweep cycle 3.
    step(1'b0, 1'b0, 0, 2'b00, 0, 1'b1);
    idle_step();
    idle_step();
    step(1'b1, 1'b0, 0, 2'b00, 0, 1'b0);
    check("rst_sweep_busy", 64'(busy), 64'h0);
    check("rst_sweep_osel", 64'(osel), 64'h0);
    step(1'b0, 1'b0, 0, 2'b00, 0, 1'b0);
    check("rst_sweep_ready", 64'(wr_ready), 64'h1);

`ifdef OSEL_PARITY_EN
    step(1'b0, 1'b1, 2, 2'b00, 4'b0111, 1'b0);
    check("par_odd", 64'(osel_par[2]), 64'h1);
    step(1'b0, 1'b1, 2, 2'b11, 4'b0001, 1'b0);
    check("par_even", 64'(osel_par[2]), 64'h0);
`endif

    // clr_req held as a level: back-to-back sweeps with one idle cycle between.
    step(1'b0, 1'b1, 0, 2'b00, 4'hF, 1'b0);
    for (int c = 0; c < 2 * NSLOT + 3; c++) step(1'b0, 1'b0, 0, 2'b00, 0, 1'b1);
    idle_step();

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 99) < 60),
           int'($urandom_range(0, (1 << IDX_W) - 1)),
           2'($urandom_range(0, 3)),
           int'($urandom_range(0, (1 << SLOT_W) - 1)),
           ($urandom_range(0, 99) < 4));
    end
    idle_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
